// File: rtl/cmp_pkg.sv
// Shared types for the serial operand loader and its comparator stage.
// Holds the loader FSM encoding, the result bundle and a width helper.
package cmp_pkg;

    // Loader FSM: shift bits in, let the comparator settle, hold the result.
    typedef enum logic [1:0] {
        ST_SHIFT  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Captured comparison; exactly one field is set while a result is held.
    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_res_t;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_capture_reg.sv
// Per-operand parallel register loaded one bit at a time at a given index.
// Index 0 is the operand MSB; i_clr has priority over i_load.
module shift_capture_reg #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_bit,
    output logic [0:WIDTH-1] o_q
);

    logic [0:WIDTH-1] r_q;

    // Clear the whole operand, or write one serial bit into its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q[i_idx] <= i_bit;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/operand_serial_loader.sv
// Bit-serial front end feeding a magnitude comparator and capturing its result.
// Optional build macro SERIAL_LSB_FIRST_EN: serial line carries the LSB first.
module operand_serial_loader
    import cmp_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    output logic [0:WIDTH-1] op_a,
    output logic [0:WIDTH-1] op_b,
    output logic             op_valid,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_eq,
    output logic             res_lt,
    output logic             res_gt
);

    localparam int CNT_W = clog2(WIDTH);
    localparam int SET_W = clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [SET_W-1:0] r_set_cnt;
    cmp_res_t         r_res;

    logic             w_accept;
    logic             w_last_beat;
    logic             w_last_set;
    logic             w_capture;
    logic             w_consume;
    logic [CNT_W-1:0] w_idx;

    assign w_last_beat = (r_bit_cnt == LAST_BIT);
    assign w_last_set  = (r_set_cnt == LAST_SET);

    // Serial position to parallel index; the parallel numbering never changes.
`ifdef SERIAL_LSB_FIRST_EN
    assign w_idx = LAST_BIT - r_bit_cnt;
`else
    assign w_idx = r_bit_cnt;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SHIFT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus handshake strobes and state-only outputs.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_consume = 1'b0;
        in_ready  = 1'b0;
        op_valid  = 1'b0;
        res_valid = 1'b0;
        unique case (r_state)
            ST_SHIFT: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && w_last_beat) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                op_valid = 1'b1;
                if (w_last_set) begin
                    w_capture = 1'b1;
                    w_next    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                op_valid  = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    w_consume = 1'b1;
                    w_next    = ST_SHIFT;
                end
            end
            default: begin
                w_next = ST_SHIFT;
            end
        endcase
    end

    // Beat counter: advances per accepted bit, wraps after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= w_last_beat ? '0 : r_bit_cnt + 1'b1;
        end
    end

    // Settle counter: runs only while operands are being held for settling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_set_cnt <= '0;
        end else if (r_state == ST_SETTLE) begin
            r_set_cnt <= w_last_set ? '0 : r_set_cnt + 1'b1;
        end else begin
            r_set_cnt <= '0;
        end
    end

    // Result capture; an illegal eq+lt from the comparator resolves to eq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
        end else if (w_capture) begin
            r_res.eq <= cmp_eq;
            r_res.lt <= cmp_lt & ~cmp_eq;
            r_res.gt <= ~cmp_eq & ~cmp_lt;
        end else if (w_consume) begin
            r_res <= '0;
        end
    end

    assign res_eq = r_res.eq;
    assign res_lt = r_res.lt;
    assign res_gt = r_res.gt;

    shift_capture_reg #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_reg_a (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_consume),
        .i_load (w_accept),
        .i_idx  (w_idx),
        .i_bit  (in_a),
        .o_q    (op_a)
    );

    shift_capture_reg #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_reg_b (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_consume),
        .i_load (w_accept),
        .i_idx  (w_idx),
        .i_bit  (in_b),
        .o_q    (op_b)
    );

endmodule

// File: doc/operand_serial_loader.md
# operand_serial_loader

Bit-serial operand front end for the 8-bit magnitude comparator. It shifts two operands in one bit per accepted beat and presents them in parallel to the downstream combinational comparator. After a fixed settle window it captures the comparator's equal/less outputs and returns a registered, handshaked result. It is both the upstream feeder and the result consumer of the comparator stage.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..16
- SETTLE_CYCLES, 2, cycles operands are held stable before the comparator outputs are sampled; minimum 1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  a bit pair is present on in_a/in_b
- in_ready  out  1  loader accepts a bit pair this cycle
- in_a  in  1  next serial bit of operand A
- in_b  in  1  next serial bit of operand B
- op_a  out  [0:WIDTH-1]  parallel operand A to comparator; index 0 is the MSB
- op_b  out  [0:WIDTH-1]  parallel operand B to comparator; index 0 is the MSB
- op_valid  out  1  op_a/op_b are complete and held stable
- cmp_eq  in  1  comparator equal output
- cmp_lt  in  1  comparator A<B output
- res_valid  out  1  result registers hold a captured comparison
- res_ready  in  1  consumer takes the result
- res_eq, res_lt, res_gt  out  1 each  captured result; exactly one is high while res_valid=1

## Operation
- FSM states are SHIFT, SETTLE and HOLD. Reset enters SHIFT.
- SHIFT:
  - in_ready=1.
  - On in_valid&in_ready, in_a/in_b are written into the next position of op_a/op_b and the bit counter increments.
  - Default order is MSB first: the first beat lands in index 0 and the last beat in index WIDTH-1.
  - On the WIDTH-th accepted beat, the counter clears and the FSM goes to SETTLE.
- SETTLE:
  - in_ready=0, op_valid=1, and op_a/op_b are frozen.
  - A settle counter runs for SETTLE_CYCLES cycles.
  - On the last settle cycle, cmp_eq/cmp_lt are registered and the FSM goes to HOLD.
- HOLD:
  - res_valid=1 and op_valid=1. Operands and results are frozen.
  - res_gt = !cmp_eq & !cmp_lt, computed at capture.
  - Combinational eq=lt=1 from the comparator is illegal. The loader captures res_eq=1, res_lt=0, res_gt=0 in that case (eq wins).
  - On res_valid&res_ready, the FSM returns to SHIFT, clears op_a/op_b/results, and deasserts op_valid/res_valid on the next cycle.
- in_valid is ignored outside SHIFT. No bit is lost, because in_ready=0 there.
- No back-to-back overlap: a new operand pair cannot begin shifting until the result is consumed.

## Timing
- Reset values:
  - in_ready=1 (state SHIFT).
  - op_a=op_b=0, op_valid=0.
  - res_valid=res_eq=res_lt=res_gt=0.
  - Both counters 0.
- Reset mid-shift or mid-settle discards partial operands immediately (asynchronous). The first beat after reset release loads index 0.
- Latency with continuous in_valid:
  - WIDTH accept cycles.
  - op_valid rises the cycle after the WIDTH-th accept.
  - res_valid rises SETTLE_CYCLES cycles after op_valid.
  - Total from first accept edge to res_valid: WIDTH+SETTLE_CYCLES cycles.
- Gaps in in_valid during SHIFT stall the counter. No timeout.
- If res_ready is already high when res_valid rises, the result is consumed in that cycle. in_ready returns to 1 on the following cycle. Minimum turnaround per comparison is WIDTH+SETTLE_CYCLES+1 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid/res_ready to any output.

## Configuration
- SERIAL_LSB_FIRST_EN:
  - Defined: the first accepted beat lands in index WIDTH-1 and the last beat in index 0 (LSB first on the serial line).
  - Undefined: MSB first as above.
- The parallel op_a/op_b bit numbering (index 0 = MSB) is identical in both builds.

## Structure
- The shared package cmp_pkg holds:
  - the state enum (SHIFT, SETTLE, HOLD)
  - the counter-width function clog2(WIDTH)
  - the result struct {eq, lt, gt}
- One sub-module, shift_capture_reg. It is the per-operand WIDTH-bit indexed load register with clear, and is instantiated twice (A and B).
- The FSM and counters live in the top module.

## Test plan
- Reset, then shift A=8'b1000_0000 and B=8'b0000_0000 MSB first, continuous in_valid, res_ready=1, comparator model attached:
  - op_valid rises after the 8th accept.
  - res_valid rises 2 cycles later with res_gt=1.
- Shift A=B=8'hA5:
  - res_eq=1, res_lt=0, res_gt=0.
  - in_ready returns to 1 the cycle after the handshake.
- Shift A=8'h3C and B=8'h7F with in_valid toggling every other cycle:
  - exactly 8 beats are accepted and res_lt=1.
  - Hold res_ready=0 for 5 cycles: outputs stay frozen and in_ready=0.
- Assert rst for one cycle after the 5th beat of A=8'hFF/B=8'h00, then shift A=8'h01/B=8'h02:
  - outputs return to reset values immediately.
  - result is res_lt=1 (no residue from the aborted shift).
- Force cmp_eq=cmp_lt=1 during SETTLE: captured result is res_eq=1 only.
- With SERIAL_LSB_FIRST_EN defined, shift serial bits 1,0,0,0,0,0,0,0 for A and zeros for B:
  - op_a=8'b0000_0001 (index 7 set) and res_gt=1.
